// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_rx_state_t;

    // ParityMode encodings; 2'd3 is reserved and behaves as PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // StopBits encodings
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX input conditioning: 2-flop synchroniser, falling-edge detect and the
// bit value used at the mid-bit decision point.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 majority sample.
module uart_rx_sampler (
    input  logic Clk,
    input  logic Rst,
    input  logic RX,
    output logic rx_s,
    output logic fall_edge,
    output logic sample_bit
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronise the pad and remember the previous synchronised level
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], RX};
            prev_q <= sync_q[1];
        end
    end

    assign rx_s      = sync_q[1];
    assign fall_edge = prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // Two delayed taps; together with rx_s they span three consecutive cycles
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= {maj_q[0], rx_s};
        end
    end

    assign sample_bit = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, bit/data counters and a one-entry
// valid/ready output buffer with overrun detection.
// Build option: UART_RX_MAJORITY_EN moves the bit decision to OVS/2 and uses
// a 2-of-3 majority sample (one extra cycle of latency).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clear,
    input  logic                 RX,
    input  logic [1:0]           ParityMode,
    input  logic                 StopBits,
    output logic [DATA_BITS-1:0] OutData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 ParityErr,
    output logic                 FrameErr,
    output logic                 Overrun
);

    localparam int CW = $clog2(OVS);
    localparam int DW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] SAMPLE_PT = CW'(OVS / 2);
`else
    localparam logic [CW-1:0] SAMPLE_PT = CW'(OVS / 2 - 1);
`endif
    localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);

    logic rx_s, fall_edge, sample_bit;

    uart_rx_sampler u_sampler (
        .Clk        (Clk),
        .Rst        (Rst),
        .RX         (RX),
        .rx_s       (rx_s),
        .fall_edge  (fall_edge),
        .sample_bit (sample_bit)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]        data_cnt_q, data_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic [1:0]           par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic [DATA_BITS-1:0] obuf_q, obuf_d;
    logic                 oval_q, oval_d, operr_q, operr_d, oferr_q, oferr_d;
    logic                 ovr_q, ovr_d;
    logic                 push, push_ferr, at_mid, at_end, par_en;

    assign at_mid = (bit_cnt_q == SAMPLE_PT);
    assign at_end = (bit_cnt_q == BIT_LAST);
    assign par_en = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

    // Frame FSM: counters, shift register, error accumulation and push request
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        data_cnt_d = data_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        push       = 1'b0;
        push_ferr  = ferr_q;

        if (state_q != ST_IDLE) begin
            bit_cnt_d = at_end ? '0 : bit_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (fall_edge && !rx_s) begin
                    state_d    = ST_START;
                    par_d      = ParityMode;
                    stop2_d    = StopBits;
                    data_cnt_d = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                if (at_mid && sample_bit) begin
                    // Line back high at mid-start: a glitch, not a frame
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else if (at_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_mid) begin
                    shreg_d = {sample_bit, shreg_q[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    if (data_cnt_q == DATA_LAST) begin
                        data_cnt_d = '0;
                        state_d    = par_en ? ST_PARITY : ST_STOP1;
                    end else begin
                        data_cnt_d = data_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid) begin
                    perr_d = (par_q == PAR_ODD) ? ~(^shreg_q ^ sample_bit)
                                                :  (^shreg_q ^ sample_bit);
                end
                if (at_end) begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (at_mid) begin
                    ferr_d = ferr_q | ~sample_bit;
                    if (stop2_q == STOP_1) begin
                        push      = 1'b1;
                        push_ferr = ferr_q | ~sample_bit;
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end
                end else if (at_end) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (at_mid) begin
                    ferr_d    = ferr_q | ~sample_bit;
                    push      = 1'b1;
                    push_ferr = ferr_q | ~sample_bit;
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (Clear) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            data_cnt_d = '0;
            push       = 1'b0;
        end
    end

    // One-entry output buffer: load, replace-on-accept, overrun drop, pop
    always_comb begin
        obuf_d  = obuf_q;
        oval_d  = oval_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        ovr_d   = 1'b0;

        if (push) begin
            if (!oval_q || OutReady) begin
                obuf_d  = shreg_q;
                oval_d  = 1'b1;
                operr_d = perr_q;
                oferr_d = push_ferr;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (oval_q && OutReady) begin
            oval_d  = 1'b0;
            operr_d = 1'b0;
            oferr_d = 1'b0;
        end

        if (Clear) begin
            oval_d  = 1'b0;
            operr_d = 1'b0;
            oferr_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_q      <= PAR_NONE;
            stop2_q    <= STOP_1;
            obuf_q     <= '0;
            oval_q     <= 1'b0;
            operr_q    <= 1'b0;
            oferr_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            data_cnt_q <= data_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            obuf_q     <= obuf_d;
            oval_q     <= oval_d;
            operr_q    <= operr_d;
            oferr_q    <= oferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign OutData   = obuf_q;
    assign OutValid  = oval_q;
    assign ParityErr = operr_q;
    assign FrameErr  = oferr_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8-bit and a 7-bit instance, OVS = 16.
module tb_uart_rx_cfg;

    localparam int OVS = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Clear = 1'b0;
    logic       rx8 = 1'b1, rx7 = 1'b1;
    logic [1:0] pm8 = 2'd0, pm7 = 2'd0;
    logic       sb8 = 1'b0, sb7 = 1'b0;
    logic       rdy8 = 1'b1, rdy7 = 1'b1;

    logic [7:0] OutData8;
    logic       OutValid8, ParityErr8, FrameErr8, Overrun8;
    logic [6:0] OutData7;
    logic       OutValid7, ParityErr7, FrameErr7, Overrun7;

    uart_rx_cfg #(.DATA_BITS(8), .OVS(OVS)) u8 (
        .Clk(Clk), .Rst(Rst), .Clear(Clear), .RX(rx8),
        .ParityMode(pm8), .StopBits(sb8),
        .OutData(OutData8), .OutValid(OutValid8), .OutReady(rdy8),
        .ParityErr(ParityErr8), .FrameErr(FrameErr8), .Overrun(Overrun8)
    );

    uart_rx_cfg #(.DATA_BITS(7), .OVS(OVS)) u7 (
        .Clk(Clk), .Rst(Rst), .Clear(Clear), .RX(rx7),
        .ParityMode(pm7), .StopBits(sb7),
        .OutData(OutData7), .OutValid(OutValid7), .OutReady(rdy7),
        .ParityErr(ParityErr7), .FrameErr(FrameErr7), .Overrun(Overrun7)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr8 = 0, ovr7 = 0;
    int   rise8 = -1;
    logic vprev8 = 1'b0;

    function automatic exp_t mk(input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor for the 8-bit instance: compare every accepted word
    always @(negedge Clk) begin
        if (!Rst) begin
            if (OutValid8 && rdy8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u8_unexpected_word: got 0x%0h, expected no word", OutData8);
                end else begin
                    e8 = q8.pop_front();
                    check("u8_data", {24'd0, OutData8}, {23'd0, e8.d});
                    check("u8_perr", {31'd0, ParityErr8}, {31'd0, e8.pe});
                    check("u8_ferr", {31'd0, FrameErr8}, {31'd0, e8.fe});
                end
            end
            if (Overrun8) ovr8++;
            if (OutValid8 && !vprev8) rise8 = cyc;
            vprev8 = OutValid8;
        end
    end

    // Monitor for the 7-bit instance
    always @(negedge Clk) begin
        if (!Rst) begin
            if (OutValid7 && rdy7) begin
                if (q7.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u7_unexpected_word: got 0x%0h, expected no word", OutData7);
                end else begin
                    e7 = q7.pop_front();
                    check("u7_data", {25'd0, OutData7}, {23'd0, e7.d});
                    check("u7_perr", {31'd0, ParityErr7}, {31'd0, e7.pe});
                    check("u7_ferr", {31'd0, FrameErr7}, {31'd0, e7.fe});
                end
            end
            if (Overrun7) ovr7++;
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 8) rx8 = v;
        else rx7 = v;
    endtask

    task automatic hold_bit(input int which, input logic v);
        drive(which, v);
        repeat (OVS) @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int which, input int nbits);
        for (int i = 0; i < nbits; i++) hold_bit(which, 1'b1);
    endtask

    // pbit < 0 means no parity bit on the wire
    task automatic send(input int which, input logic [8:0] d, input int nbits,
                        input int pbit, input logic s1, input logic s2,
                        input int nstop, output int stop_cyc);
        hold_bit(which, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(which, d[i]);
        if (pbit >= 0) hold_bit(which, pbit[0]);
        stop_cyc = cyc;
        hold_bit(which, s1);
        if (nstop == 2) hold_bit(which, s2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;

        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_valid8", {31'd0, OutValid8}, 32'd0);
        check("rst_data8", {24'd0, OutData8}, 32'd0);
        check("rst_perr8", {31'd0, ParityErr8}, 32'd0);
        check("rst_ferr8", {31'd0, FrameErr8}, 32'd0);
        check("rst_ovr8", {31'd0, Overrun8}, 32'd0);
        check("rst_valid7", {31'd0, OutValid7}, 32'd0);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        idle(8, 2);

        // 8N1 0xA5 and its latency from the stop mid-sample
        q8.push_back(mk(9'h0A5, 1'b0, 1'b0));
        send(8, 9'h0A5, 8, -1, 1'b1, 1'b1, 1, sc);
        idle(8, 2);
        check("latency_8n1", 32'(rise8 - sc), 32'(3 + OVS / 2));
        check("valid_drops", {31'd0, OutValid8}, 32'd0);

        // 7-bit even parity: wrong bit, right bit, then odd parity right bit
        pm7 = 2'd1;
        q7.push_back(mk(9'h035, 1'b1, 1'b0));
        send(7, 9'h035, 7, 1, 1'b1, 1'b1, 1, sc);
        q7.push_back(mk(9'h035, 1'b0, 1'b0));
        send(7, 9'h035, 7, 0, 1'b1, 1'b1, 1, sc);
        pm7 = 2'd2;
        q7.push_back(mk(9'h035, 1'b0, 1'b0));
        send(7, 9'h035, 7, 1, 1'b1, 1'b1, 1, sc);
        idle(7, 2);

        // 8N2 with bad second stop bit, then two back-to-back good frames
        sb8 = 1'b1;
        q8.push_back(mk(9'h03C, 1'b0, 1'b1));
        send(8, 9'h03C, 8, -1, 1'b1, 1'b0, 2, sc);
        idle(8, 1);
        q8.push_back(mk(9'h000, 1'b0, 1'b0));
        send(8, 9'h000, 8, -1, 1'b1, 1'b1, 2, sc);
        q8.push_back(mk(9'h081, 1'b0, 1'b0));
        send(8, 9'h081, 8, -1, 1'b1, 1'b1, 2, sc);
        idle(8, 2);
        sb8 = 1'b0;

        // Short low glitch in idle, then a normal frame
        drive(8, 1'b0);
        repeat (4) @(posedge Clk);
        #1;
        drive(8, 1'b1);
        idle(8, 2);
        check("glitch_no_valid", {31'd0, OutValid8}, 32'd0);
        q8.push_back(mk(9'h05A, 1'b0, 1'b0));
        send(8, 9'h05A, 8, -1, 1'b1, 1'b1, 1, sc);
        idle(8, 2);

        // Overrun: consumer stalled across two frames
        rdy8 = 1'b0;
        q8.push_back(mk(9'h011, 1'b0, 1'b0));
        send(8, 9'h011, 8, -1, 1'b1, 1'b1, 1, sc);
        send(8, 9'h022, 8, -1, 1'b1, 1'b1, 1, sc);
        idle(8, 2);
        check("overrun_count", 32'(ovr8), 32'd1);
        check("overrun_keep_valid", {31'd0, OutValid8}, 32'd1);
        check("overrun_keep_data", {24'd0, OutData8}, 32'h11);
        rdy8 = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("pop_valid_low", {31'd0, OutValid8}, 32'd0);

        // Clear in the middle of the data bits of 0x77
        hold_bit(8, 1'b0);
        hold_bit(8, 1'b1);
        hold_bit(8, 1'b1);
        drive(8, 1'b1);
        repeat (5) @(posedge Clk);
        #1;
        Clear = 1'b1;
        @(posedge Clk);
        #1;
        Clear = 1'b0;
        idle(8, 12);
        check("clear_no_valid", {31'd0, OutValid8}, 32'd0);
        check("clear_queue_empty", 32'(q8.size()), 32'd0);

        // Asynchronous reset mid-frame while a word is buffered
        rdy8 = 1'b0;
        send(8, 9'h099, 8, -1, 1'b1, 1'b1, 1, sc);
        hold_bit(8, 1'b0);
        drive(8, 1'b1);
        repeat (5) @(posedge Clk);
        #1;
        check("pre_rst_valid", {31'd0, OutValid8}, 32'd1);
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, OutValid8}, 32'd0);
        check("async_rst_data", {24'd0, OutData8}, 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        rdy8 = 1'b1;
        idle(8, 2);
        q8.push_back(mk(9'h0C3, 1'b0, 1'b0));
        send(8, 9'h0C3, 8, -1, 1'b1, 1'b1, 1, sc);
        idle(8, 2);

        for (int i = 0; i < 200 && (q8.size() != 0 || q7.size() != 0); i++) @(posedge Clk);
        #1;
        check("final_q8_empty", 32'(q8.size()), 32'd0);
        check("final_q7_empty", 32'(q7.size()), 32'd0);
        check("final_ovr7", 32'(ovr7), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the team's fixed 8-bit, 16x-oversampled UART receiver.
- Data width, oversampling ratio, parity mode and stop-bit count are configurable.
- Adds framing/parity error reporting, a one-entry valid/ready output buffer with overrun detection, and an input synchroniser.
- Sits between the RX pad and the UART register/FIFO block, all on the core clock.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
OVS, 16, core-clock cycles per bit; power of two, legal 4..64.

Ports:
Clk  in  1  core clock; also the oversampling clock.
Rst  in  1  asynchronous, active-high reset.
Clear  in  1  synchronous clear: abort frame, drop buffered word, clear flags.
RX  in  1  serial input, idle high, asynchronous to Clk.
ParityMode  in  2  0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none).
StopBits  in  1  0 = one stop bit, 1 = two stop bits.
OutData  out  DATA_BITS  received word, LSB = first bit on the wire.
OutValid  out  1  buffered word available.
OutReady  in  1  consumer accepts the word when OutValid && OutReady.
ParityErr  out  1  parity error flag for the buffered word.
FrameErr  out  1  stop-bit error flag for the buffered word.
Overrun  out  1  one-cycle pulse: a completed word was dropped.

Behaviour:
Reset values:
- OutData = 0; OutValid, ParityErr, FrameErr, Overrun = 0.
- Synchroniser flops = 1; state = IDLE; all counters = 0.

Input path and counters:
- RX passes through a 2-flop synchroniser (rx_s). Each sample below refers to rx_s, not raw RX.
- bit_cnt counts 0..OVS-1 while a frame is active.
- Mid-bit sample point: bit_cnt == OVS/2-1. Bit boundary: bit_cnt == OVS-1.

State machine: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: a 1->0 transition on rx_s enters START with bit_cnt = 0. ParityMode and StopBits are captured here and held for the whole frame.
- START, at the mid-bit sample: rx_s == 1 is a glitch; return to IDLE with no output and no flag. Otherwise continue, and move to DATA at the bit boundary.
- DATA: shift rx_s in at each mid-bit sample, LSB first. After the DATA_BITS-th bit boundary go to PARITY if parity is enabled, otherwise STOP1.
- PARITY: sample at mid-bit. perr = (XOR of data ^ sample) != 0 for even parity; (XOR of data ^ sample) != 1 for odd parity. Go to STOP1 at the bit boundary.
- STOP1: sample at mid-bit; a 0 sets ferr. With one stop bit, the frame completes at this sample and the FSM goes to IDLE on the next cycle. With two stop bits, go to STOP2 at the bit boundary.
- STOP2: sample at mid-bit, same rule as STOP1; the frame completes there and the FSM goes to IDLE.
- Returning to IDLE at mid-stop lets a back-to-back start bit be detected.

Output buffer:
- Frame completion produces a push in the cycle after the final stop sample, with {data, perr, ferr}. Latency from the final stop sample cycle to OutValid = 1 cycle.
- Errored words are still delivered, with their flags set.
- ParityErr and FrameErr are stable while OutValid = 1. They are 0 whenever OutValid = 0.
- Push while OutValid = 0: load the word, set OutValid.
- Push while OutValid = 1 and OutReady = 0: drop the new word, pulse Overrun for 1 cycle, keep the old word.
- Push while OutValid = 1 and OutReady = 1 (same cycle): replace the word, OutValid stays 1, no Overrun.
- Pop only (no push): OutValid goes to 0 on the next cycle.

Clear and reset mid-frame:
- Clear has priority over every other event. Next cycle: IDLE, counters 0, OutValid = 0, flags 0, synchroniser not cleared.
- Rst asserted mid-frame: all state returns to reset values immediately.

Width rules:
- DATA_BITS < 8 is legal; OutData is exactly DATA_BITS wide.
- Counters are sized with $clog2(OVS) and $clog2(DATA_BITS+1) bits. They never exceed range; bit_cnt wraps to 0 at the bit boundary.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each mid-bit sample is the 2-of-3 majority of rx_s at bit_cnt = OVS/2-2, OVS/2-1 and OVS/2. The decision is used at OVS/2, so DATA/PARITY/STOP decisions and the push are delayed 1 cycle, and OutValid latency becomes 2 cycles after the last stop sample point. The start-glitch check also uses the majority result.
- Undefined: single sample at OVS/2-1, as described above.

Decomposition:
- Package uart_pkg:
  - state enum type uart_rx_state_t;
  - parity mode localparams PAR_NONE, PAR_EVEN, PAR_ODD;
  - stop-bit localparams STOP_1, STOP_2.
- One sub-module, uart_rx_sampler:
  - 2-flop synchroniser plus edge detect;
  - under UART_RX_MAJORITY_EN, a 3-tap majority shift register.
  - Outputs: rx_s, fall_edge, sample_bit.
- FSM, counters and output buffer stay in uart_rx_cfg.

Test Plan:
- 8N1, OVS = 16, send 0xA5, OutReady = 1 -> OutValid for 1 cycle, OutData = 0xA5, ParityErr = 0, FrameErr = 0; OutValid rises 1 cycle after the stop mid-sample.
- DATA_BITS = 7, ParityMode = 1 (even), send 0x35 with parity bit 1 (wrong; correct is 0) -> OutData = 0x35, ParityErr = 1. Repeat with parity bit 0 -> ParityErr = 0.
- 8N2, send 0x3C with the second stop bit = 0 -> FrameErr = 1, OutData = 0x3C. Next frame 0x00 sent back-to-back -> received correctly, FrameErr = 0.
- RX low for 4 cycles (less than OVS/2) in IDLE -> back to IDLE, no OutValid, no flags. A following valid frame 0x5A is received correctly.
- OutReady = 0, send 0x11 then 0x22 -> Overrun pulses once at the 0x22 completion, OutData stays 0x11. Raise OutReady -> 0x11 accepted, OutValid = 0.
- Clear asserted mid-DATA of 0x77 -> no output. Rst pulsed mid-frame -> all outputs 0 immediately. Subsequent 0xC3 frame is received correctly.
